mem_bank_mapper: RTL and testbench
==================================

Name: mem_bank_mapper

Overview:
- Parametrised successor to the fixed memory address decoder for the S100 Z80 FPGA SBC.
- Splits the logical address space into 4 KB pages and maps each page through an I/O-programmable page register onto a wider physical address.
- Generates ROM, RAM and VGA RAM chip selects, plus a per-region wait-state ready signal.
- Sits between the Z80 core bus and the on-chip ROM, external SRAM and VGA RAM.

Parameters:
- PHYS_W, 20: physical address width. Range 13..20, so a page number fits in 8 bits.
- IO_BASE, 8'h78: base I/O port. IO_BASE+0 = index, IO_BASE+1 = page data, IO_BASE+2 = control.
- ROM_PAGE, 4'hF: logical page decoded as ROM.
- VRAM_PAGE, 4'hE: logical page decoded as VGA RAM.
- ROM_WAIT, 2: wait cycles for ROM accesses, 0..7.
- RAM_WAIT, 0: wait cycles for RAM and VGA RAM accesses, 0..7.

Ports:
- clock  in  1  system clock
- n_reset  in  1  synchronous reset, active-low
- address  in  16  logical CPU address
- memread  in  1  memory read strobe
- memwrite  in  1  memory write strobe
- n_jorphant  in  1  low = external S100 memory owns the cycle; suppresses ram_cs
- io_addr  in  8  I/O port address
- io_wr  in  1  I/O write strobe, one cycle per write
- io_rd  in  1  I/O read strobe
- io_din  in  8  I/O write data
- io_dout  out  8  I/O read data
- io_hit  out  1  I/O read addresses one of this block's ports
- phys_addr  out  PHYS_W  translated physical address
- rom_cs  out  1  ROM select, high active
- ram_cs  out  1  RAM select, high active
- vgaRam_cs  out  1  VGA RAM select, high active
- mem_ready  out  1  low = insert a wait state

Behaviour:
- Single clock domain. n_reset is sampled on the rising clock edge, active-low.
- Registers:
  - page_idx[3:0]
  - page_reg[0..15], each PHYS_W-12 bits
  - ctrl[2:0]: bit0 map_en, bit1 rom_en, bit2 vram_en
  - wait counter cnt[2:0]
  - acc_d: registered (memread|memwrite)
- Reset values: page_reg[k] = k zero-extended (identity map), page_idx = 0, map_en = 0, rom_en = 1, vram_en = 0, cnt = 0, acc_d = 0.
- Output values after reset:
  - rom_cs, ram_cs and vgaRam_cs are 0 while no strobe is active.
  - mem_ready = 1.
  - io_dout = 0, io_hit = 0.
- I/O writes on io_wr, effective at the next edge:
  - IO_BASE: page_idx <= io_din[3:0].
  - IO_BASE+1: page_reg[page_idx] <= io_din[PHYS_W-13:0]; page_idx then increments mod 16 (15 wraps to 0).
  - IO_BASE+2: ctrl <= io_din[2:0].
  - Any other port is ignored.
- Decode is combinational on the current register state:
  - lp = address[15:12]; acc = memread|memwrite.
  - rom_cs = (lp==ROM_PAGE) & memread & rom_en. ROM is read-only; a memwrite to the ROM page falls through to RAM.
  - vgaRam_cs = (lp==VRAM_PAGE) & acc & vram_en & !rom_cs.
  - ram_cs = acc & n_jorphant & !rom_cs & !vgaRam_cs.
  - phys_addr = map_en ? {page_reg[lp], address[11:0]} : zero-extended address. This applies to every region.
- Priority when regions overlap: ROM > VGA RAM > RAM.
- I/O write coinciding with a memory access: the access uses the pre-write register values. The new value applies from the next cycle.
- Wait states:
  - start = acc & !acc_d.
  - W = ROM_WAIT if rom_cs, else RAM_WAIT.
  - On start with W>0: cnt <= W-1.
  - While cnt != 0: cnt decrements by 1.
  - mem_ready = !((start & W!=0) | cnt!=0). ready is therefore low for exactly W cycles, starting at the start cycle.
  - A strobe that stays high produces only one wait sequence.
  - A strobe dropping mid-count does not abort the count.
- Reset asserted mid-access or mid-count: all registers return to reset values on that edge; mem_ready is 1 in the following cycle.

Optional Feature:
- Macro: MEM_BANK_MAPPER_READBACK_EN.
- Defined:
  - io_rd to IO_BASE returns {4'b0, page_idx}.
  - io_rd to IO_BASE+1 returns page_reg[page_idx], zero-extended to 8 bits. A read does not increment page_idx.
  - io_rd to IO_BASE+2 returns {5'b0, ctrl}.
  - io_hit is high whenever io_rd addresses one of these three ports.
  - io_dout and io_hit are combinational.
- Undefined: io_dout = 0 and io_hit = 0 at all times.

Test Plan:
- Reset, then memread at 16'hF123 -> rom_cs=1, phys_addr=20'h0F123; mem_ready low for 2 cycles, then high.
- Write IO_BASE=3, IO_BASE+1=8'h5A, IO_BASE+2=3'b011; then memwrite at 16'h3456 -> ram_cs=1, phys_addr=20'h5A456, page_idx=4.
- ctrl=3'b100; memread at 16'hE010 -> vgaRam_cs=1, rom_cs=0, ram_cs=0. Then ctrl=3'b000; memread at 16'hF000 -> ram_cs=1.
- page_idx=15, write data 8'h80 -> page_reg[15]=8'h80, page_idx wraps to 0. Memwrite at 16'hF000 with rom_en=1 -> ram_cs=1, rom_cs=0.
- ROM read in progress with cnt=1; pull n_reset low for one edge -> mem_ready=1, map_en=0, page_reg[5]=5 on the next cycle.
- With MEM_BANK_MAPPER_READBACK_EN defined: io_rd at IO_BASE+2 after writing 8'h07 -> io_dout=8'h07, io_hit=1. Without the macro: io_dout=0, io_hit=0.

Source files
------------

// File: rtl/mem_bank_mapper.sv
// Z80 bank mapper: 4 KB logical pages are remapped to a wider physical address; ROM/RAM/VGA RAM selects plus wait states.
// Decode is combinational (0 cycles); register writes take effect at the next edge. Stalls the CPU through mem_ready.
// MEM_BANK_MAPPER_READBACK_EN adds I/O readback of the index, page and control registers.
module mem_bank_mapper #(
    parameter int         PHYS_W    = 20,
    parameter logic [7:0] IO_BASE   = 8'h78,
    parameter logic [3:0] ROM_PAGE  = 4'hF,
    parameter logic [3:0] VRAM_PAGE = 4'hE,
    parameter int         ROM_WAIT  = 2,
    parameter int         RAM_WAIT  = 0
) (
    input  logic              clock,
    input  logic              n_reset,
    input  logic [15:0]       address,
    input  logic              memread,
    input  logic              memwrite,
    input  logic              n_jorphant,
    input  logic [7:0]        io_addr,
    input  logic              io_wr,
    input  logic              io_rd,
    input  logic [7:0]        io_din,
    output logic [7:0]        io_dout,
    output logic              io_hit,
    output logic [PHYS_W-1:0] phys_addr,
    output logic              rom_cs,
    output logic              ram_cs,
    output logic              vgaRam_cs,
    output logic              mem_ready
);

    localparam int         PG_W     = PHYS_W - 12;
    localparam logic [7:0] PORT_IDX = IO_BASE;
    localparam logic [7:0] PORT_DAT = IO_BASE + 8'd1;
    localparam logic [7:0] PORT_CTL = IO_BASE + 8'd2;
    localparam logic [2:0] ROM_W    = 3'(ROM_WAIT);
    localparam logic [2:0] RAM_W    = 3'(RAM_WAIT);

    logic [PG_W-1:0] page_q [16];
    logic [PG_W-1:0] page_d [16];
    logic [3:0]      idx_q, idx_d;
    logic [2:0]      ctrl_q, ctrl_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            acc_q, acc_d;

    logic [3:0] lp;
    logic       acc;
    logic       start;
    logic       wait_start;
    logic [2:0] wsel;
    logic       unused_in;

    assign lp  = address[15:12];
    assign acc = memread | memwrite;

    always_comb begin
        page_d = page_q;
        idx_d  = idx_q;
        ctrl_d = ctrl_q;
        if (io_wr) begin
            case (io_addr)
                PORT_IDX: idx_d = io_din[3:0];
                PORT_DAT: begin
                    page_d[idx_q] = io_din[PG_W-1:0];
                    idx_d         = idx_q + 4'd1;
                end
                PORT_CTL: ctrl_d = io_din[2:0];
                default: ;
            endcase
        end
    end

    // Writes to the ROM page fall through to RAM; ROM wins over VGA RAM over RAM.
    assign rom_cs    = (lp == ROM_PAGE) && memread && ctrl_q[1];
    assign vgaRam_cs = (lp == VRAM_PAGE) && acc && ctrl_q[2] && !rom_cs;
    assign ram_cs    = acc && n_jorphant && !rom_cs && !vgaRam_cs;
    assign phys_addr = ctrl_q[0] ? {page_q[lp], address[11:0]} : PHYS_W'(address);

    assign start      = acc && !acc_q;
    assign wsel       = rom_cs ? ROM_W : RAM_W;
    assign wait_start = start && (wsel != 3'd0);
    assign acc_d      = acc;
    assign mem_ready  = !(wait_start || (cnt_q != 3'd0));

    // The start cycle is itself a wait cycle, so the counter holds the remaining W-1.
    always_comb begin
        cnt_d = cnt_q;
        if (wait_start) begin
            cnt_d = wsel - 3'd1;
        end else if (cnt_q != 3'd0) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!n_reset) begin
            for (int k = 0; k < 16; k++) begin
                page_q[k] <= PG_W'(k);
            end
            idx_q  <= 4'd0;
            ctrl_q <= 3'b010;
            cnt_q  <= 3'd0;
            acc_q  <= 1'b0;
        end else begin
            page_q <= page_d;
            idx_q  <= idx_d;
            ctrl_q <= ctrl_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
        end
    end

`ifdef MEM_BANK_MAPPER_READBACK_EN
    always_comb begin
        io_dout = 8'h00;
        io_hit  = 1'b0;
        if (io_rd) begin
            case (io_addr)
                PORT_IDX: begin
                    io_hit  = 1'b1;
                    io_dout = {4'b0000, idx_q};
                end
                PORT_DAT: begin
                    io_hit  = 1'b1;
                    io_dout = 8'(page_q[idx_q]);
                end
                PORT_CTL: begin
                    io_hit  = 1'b1;
                    io_dout = {5'b00000, ctrl_q};
                end
                default: ;
            endcase
        end
    end
`else
    assign io_dout = 8'h00;
    assign io_hit  = 1'b0;
`endif

    assign unused_in = ^{io_din, io_rd};

endmodule

// File: tb/tb_mem_bank_mapper.sv
module tb_mem_bank_mapper;

    localparam int PHYS_W = 20;

    logic              clock = 1'b0;
    logic              n_reset;
    logic [15:0]       address;
    logic              memread, memwrite, n_jorphant;
    logic [7:0]        io_addr;
    logic              io_wr, io_rd;
    logic [7:0]        io_din;
    logic [7:0]        io_dout;
    logic              io_hit;
    logic [PHYS_W-1:0] phys_addr;
    logic              rom_cs, ram_cs, vgaRam_cs, mem_ready;

    always #5 clock = ~clock;

    mem_bank_mapper #(.PHYS_W(PHYS_W)) dut (
        .clock(clock), .n_reset(n_reset), .address(address),
        .memread(memread), .memwrite(memwrite), .n_jorphant(n_jorphant),
        .io_addr(io_addr), .io_wr(io_wr), .io_rd(io_rd), .io_din(io_din),
        .io_dout(io_dout), .io_hit(io_hit), .phys_addr(phys_addr),
        .rom_cs(rom_cs), .ram_cs(ram_cs), .vgaRam_cs(vgaRam_cs),
        .mem_ready(mem_ready)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // Reference state: page table, index, control, and the cycle at which the current wait ends.
    int       m_page [16];
    int       m_idx;
    bit [2:0] m_ctrl;
    int       m_busy_end;
    bit       m_prev_acc;
    int       cyc = 0;
    bit       m_start;
    int       m_w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_cmp();
        int  lp;
        bit  acc;
        bit  e_rom, e_vga, e_ram, e_rdy, e_hit;
        int  e_phys;
        int  e_dout;
        lp  = int'(address[15:12]);
        acc = memread || memwrite;
        e_rom = 0; e_vga = 0; e_ram = 0;
        if (acc) begin
            if (lp == 15 && memread && m_ctrl[1]) e_rom = 1;
            else if (lp == 14 && m_ctrl[2])       e_vga = 1;
            else if (n_jorphant)                  e_ram = 1;
        end
        e_phys = m_ctrl[0] ? m_page[lp] * 4096 + int'(address) % 4096 : int'(address);
        m_w     = e_rom ? 2 : 0;
        m_start = acc && !m_prev_acc;
        e_rdy   = (m_start && m_w > 0) ? 1'b0 : (cyc >= m_busy_end);
        e_hit = 0; e_dout = 0;
`ifdef MEM_BANK_MAPPER_READBACK_EN
        if (io_rd) begin
            if (io_addr == 8'h78)      begin e_hit = 1; e_dout = m_idx; end
            else if (io_addr == 8'h79) begin e_hit = 1; e_dout = m_page[m_idx]; end
            else if (io_addr == 8'h7A) begin e_hit = 1; e_dout = int'(m_ctrl); end
        end
`endif
        if (chk_en) begin
            chk("rom_cs", 32'(rom_cs), 32'(e_rom));
            chk("vgaRam_cs", 32'(vgaRam_cs), 32'(e_vga));
            chk("ram_cs", 32'(ram_cs), 32'(e_ram));
            chk("phys_addr", 32'(phys_addr), e_phys);
            chk("mem_ready", 32'(mem_ready), 32'(e_rdy));
            chk("io_hit", 32'(io_hit), 32'(e_hit));
            if (e_hit || !io_rd) chk("io_dout", 32'(io_dout), e_dout);
        end
    endtask

    task automatic model_upd();
        if (!n_reset) begin
            for (int k = 0; k < 16; k++) m_page[k] = k;
            m_idx = 0; m_ctrl = 3'b010; m_busy_end = 0; m_prev_acc = 0;
        end else begin
            if (m_start && m_w > 0) m_busy_end = cyc + m_w;
            m_prev_acc = memread || memwrite;
            if (io_wr) begin
                if (io_addr == 8'h78) m_idx = int'(io_din) % 16;
                else if (io_addr == 8'h79) begin
                    m_page[m_idx] = int'(io_din);
                    m_idx = (m_idx + 1) % 16;
                end else if (io_addr == 8'h7A) m_ctrl = io_din[2:0];
            end
        end
        cyc++;
    endtask

    task automatic sample();
        @(negedge clock);
        model_cmp();
    endtask

    task automatic advance();
        model_upd();
        @(posedge clock);
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic io_write(input logic [7:0] a, input logic [7:0] d);
        io_wr = 1; io_addr = a; io_din = d;
        cycle();
        io_wr = 0;
    endtask

    initial begin
        n_reset = 0; address = 16'h0000; memread = 0; memwrite = 0; n_jorphant = 1;
        io_addr = 8'h00; io_wr = 0; io_rd = 0; io_din = 8'h00;
        cycle(); cycle();
        chk_en = 1;
        n_reset = 1;

        sample();
        chk("rst_rom", 32'(rom_cs), 0);
        chk("rst_ram", 32'(ram_cs), 0);
        chk("rst_vga", 32'(vgaRam_cs), 0);
        chk("rst_ready", 32'(mem_ready), 1);
        chk("rst_dout", 32'(io_dout), 0);
        chk("rst_hit", 32'(io_hit), 0);
        advance();

        memread = 1; address = 16'hF123;
        sample();
        chk("rom_rd_cs", 32'(rom_cs), 1);
        chk("rom_rd_phys", 32'(phys_addr), 32'h0F123);
        chk("rom_wait0", 32'(mem_ready), 0);
        advance();
        sample(); chk("rom_wait1", 32'(mem_ready), 0); advance();
        sample(); chk("rom_wait_done", 32'(mem_ready), 1); advance();
        memread = 0; cycle();

        io_write(8'h78, 8'h03); io_write(8'h79, 8'h5A); io_write(8'h7A, 8'h03);
        memwrite = 1; address = 16'h3456;
        sample();
        chk("map_ram_cs", 32'(ram_cs), 1);
        chk("map_phys", 32'(phys_addr), 32'h5A456);
        chk("model_idx_inc", m_idx, 4);
        advance();
        memwrite = 0; cycle();

        io_write(8'h7A, 8'h04);
        memread = 1; address = 16'hE010;
        sample();
        chk("vga_cs", 32'(vgaRam_cs), 1);
        chk("vga_rom", 32'(rom_cs), 0);
        chk("vga_ram", 32'(ram_cs), 0);
        advance();
        memread = 0; cycle();
        io_write(8'h7A, 8'h00);
        memread = 1; address = 16'hF000;
        sample();
        chk("romoff_ram", 32'(ram_cs), 1);
        chk("romoff_rom", 32'(rom_cs), 0);
        advance();
        memread = 0; cycle();

        io_write(8'h78, 8'h0F); io_write(8'h79, 8'h80);
        chk("model_pg15", m_page[15], 32'h80);
        chk("model_idx_wrap", m_idx, 0);
        io_write(8'h7A, 8'h03);
        memwrite = 1; address = 16'hF000;
        sample();
        chk("romwr_ram", 32'(ram_cs), 1);
        chk("romwr_rom", 32'(rom_cs), 0);
        chk("romwr_phys", 32'(phys_addr), 32'h80000);
        advance();
        memwrite = 0; cycle();

        io_write(8'h78, 8'h05); io_write(8'h79, 8'h22);
        memread = 1; address = 16'hF123;
        sample(); chk("rst_mid_w0", 32'(mem_ready), 0); advance();
        n_reset = 0;
        sample(); chk("rst_mid_w1", 32'(mem_ready), 0); advance();
        n_reset = 1; memread = 0;
        sample(); chk("rst_mid_ready", 32'(mem_ready), 1); advance();
        memread = 1; address = 16'h3456;
        sample(); chk("rst_mapoff", 32'(phys_addr), 32'h03456); advance();
        memread = 0;
        io_write(8'h7A, 8'h01);
        memread = 1; address = 16'h5ABC;
        sample(); chk("rst_pg5", 32'(phys_addr), 32'h05ABC); advance();
        memread = 0;

        io_write(8'h7A, 8'h07);
        io_rd = 1; io_addr = 8'h7A;
        sample();
`ifdef MEM_BANK_MAPPER_READBACK_EN
        chk("rb_dout", 32'(io_dout), 32'h07);
        chk("rb_hit", 32'(io_hit), 1);
`else
        chk("rb_dout", 32'(io_dout), 0);
        chk("rb_hit", 32'(io_hit), 0);
`endif
        advance();
        io_rd = 0;

        for (int i = 0; i < 4000; i++) begin
            n_reset = ($urandom_range(0, 79) != 0);
            if ($urandom_range(0, 3) == 0) begin
                memread  = $urandom_range(0, 1);
                memwrite = ($urandom_range(0, 3) == 0);
            end
            case ($urandom_range(0, 3))
                0: address = {4'hF, 12'($urandom)};
                1: address = {4'hE, 12'($urandom)};
                default: address = 16'($urandom);
            endcase
            n_jorphant = ($urandom_range(0, 4) != 0);
            io_addr = 8'(8'h76 + $urandom_range(0, 5));
            io_wr   = ($urandom_range(0, 5) == 0);
            io_rd   = $urandom_range(0, 1);
            io_din  = 8'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
